challenge_b_sequencer: RTL and testbench
========================================

CHALLENGE_B_SEQUENCER -- requirements
Module: challenge_b_sequencer

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 2, giving the number of cycles each input code is held before YY is sampled; legal range 1..15.
REQ-002 The block SHALL have parameter EXPECT_MASK, 8 bits, default 8'b0010_0100, where bit k is the expected YY for input code k.
REQ-003 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 START  input  1  request a full 8-code sweep; sampled only in IDLE.
REQ-006 YY  input  1  output of the challenge_B datapath under control.
REQ-007 AA, BB, CC  output  1 each  registered drive to the datapath; {AA,BB,CC} = current code.
REQ-008 CODE  output  3  current code under test.
REQ-009 BUSY  output  1  high while a sweep is in progress.
REQ-010 DONE  output  1  one-cycle pulse at sweep completion.
REQ-011 PASS  output  1  sweep verdict; 1 when FAIL_MASK == 0.
REQ-012 FAIL_MASK  output  8  bit k set when code k produced an unexpected YY.
REQ-013 PASS_COUNT  output  4  number of codes that matched, 0..8.

Function
REQ-014 The FSM SHALL have four states: IDLE, DRIVE, SAMPLE and FIN.
REQ-015 In IDLE with START=1 at an edge: next state DRIVE; CODE=0; settle counter=SETTLE_CYCLES-1; FAIL_MASK and PASS_COUNT cleared; PASS cleared.
REQ-016 In DRIVE: counter==0 -> SAMPLE, else decrement; DRIVE therefore lasts exactly SETTLE_CYCLES cycles per code.
REQ-017 SAMPLE SHALL last 1 cycle, and at its closing edge the block SHALL compare YY with EXPECT_MASK[CODE].
REQ-018 On a match in SAMPLE, PASS_COUNT SHALL increment; on a mismatch, FAIL_MASK[CODE] SHALL be set.
REQ-019 SAMPLE with CODE<7 SHALL go to DRIVE with CODE+1 and the counter reloaded; SAMPLE with CODE==7 SHALL go to FIN with CODE held at 7.
REQ-020 FIN SHALL last 1 cycle with DONE=1 and then go to IDLE; PASS SHALL be registered at FIN entry from the final FAIL_MASK.
REQ-021 BUSY SHALL be 1 exactly in DRIVE and SAMPLE, so a sweep occupies 8*(SETTLE_CYCLES+1) BUSY cycles (24 at default), followed by 1 DONE cycle.
REQ-022 {AA,BB,CC} SHALL equal CODE in every cycle, registered with no combinational path from START.
REQ-023 START SHALL be ignored in DRIVE, SAMPLE and FIN; a START held high through FIN SHALL launch a new sweep from IDLE on the following edge.
REQ-024 FAIL_MASK, PASS_COUNT and PASS SHALL hold their values in IDLE until the next accepted START.
REQ-025 PASS_COUNT + popcount(FAIL_MASK) SHALL equal the number of SAMPLE states completed in the current sweep.

Reset
REQ-026 RESET=1 at an edge SHALL force IDLE from any state, including mid-sweep.
REQ-027 Reset SHALL set CODE=0, {AA,BB,CC}=0, BUSY=0, DONE=0, PASS=0, FAIL_MASK=0, PASS_COUNT=0 and the settle counter to 0.
REQ-028 RESET SHALL take priority over START in the same cycle, and no DONE pulse SHALL be emitted for an aborted sweep.

Verification
REQ-029 Correct datapath model (YY=1 only for codes 2 and 5), START pulse -> {AA,BB,CC} steps 0..7, each held 3 cycles; DONE at cycle 25 after acceptance; PASS=1; FAIL_MASK=8'h00; PASS_COUNT=8.
REQ-030 YY stuck at 0 -> FAIL_MASK=8'b0010_0100, PASS_COUNT=6, PASS=0.
REQ-031 YY stuck at 1 -> FAIL_MASK=8'b1101_1011, PASS_COUNT=2, PASS=0.
REQ-032 START pulsed during code 3 of a running sweep -> no restart; CODE sequence unbroken; exactly one DONE pulse.
REQ-033 RESET asserted during code 4 -> next cycle IDLE with all outputs at reset values; a subsequent START gives a full clean sweep with PASS=1.
REQ-034 START held high continuously, SETTLE_CYCLES=1 -> back-to-back sweeps of 16 BUSY cycles, each DONE followed 1 cycle later (IDLE) by BUSY again, and results cleared at each new start.

Source files
------------

// File: rtl/challenge_b_sequencer.sv
// Self-test sequencer for the challenge_B datapath: sweeps all eight {AA,BB,CC}
// codes, lets each settle, samples YY and accumulates a pass count and failure mask.
module challenge_b_sequencer #(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter logic [7:0]  EXPECT_MASK   = 8'b0010_0100
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       START,
   input  logic       YY,
   output logic       AA,
   output logic       BB,
   output logic       CC,
   output logic [2:0] CODE,
   output logic       BUSY,
   output logic       DONE,
   output logic       PASS,
   output logic [7:0] FAIL_MASK,
   output logic [3:0] PASS_COUNT,
   output logic [1:0] DBG_STATE
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DRIVE  = 2'd1,
      S_SAMPLE = 2'd2,
      S_FIN    = 2'd3
   } state_t;

   localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES - 1);

   state_t     r_state, w_next_state;
   logic [2:0] r_code, w_next_code;
   logic [3:0] r_cnt, w_next_cnt;
   logic [7:0] r_fail_mask, w_next_fail_mask;
   logic [3:0] r_pass_count, w_next_pass_count;
   logic       r_pass, w_next_pass;
   logic       w_match;
   logic [7:0] w_fail_upd;

   assign w_match    = (YY == EXPECT_MASK[r_code]);
   assign w_fail_upd = w_match ? r_fail_mask : (r_fail_mask | (8'b1 << r_code));

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state      <= S_IDLE;
         r_code       <= 3'd0;
         r_cnt        <= 4'd0;
         r_fail_mask  <= 8'd0;
         r_pass_count <= 4'd0;
         r_pass       <= 1'b0;
      end else begin
         r_state      <= w_next_state;
         r_code       <= w_next_code;
         r_cnt        <= w_next_cnt;
         r_fail_mask  <= w_next_fail_mask;
         r_pass_count <= w_next_pass_count;
         r_pass       <= w_next_pass;
      end
   end

   always_comb begin
      w_next_state      = r_state;
      w_next_code       = r_code;
      w_next_cnt        = r_cnt;
      w_next_fail_mask  = r_fail_mask;
      w_next_pass_count = r_pass_count;
      w_next_pass       = r_pass;
      case (r_state)
         S_IDLE: begin
            if (START) begin
               w_next_state      = S_DRIVE;
               w_next_code       = 3'd0;
               w_next_cnt        = RELOAD;
               w_next_fail_mask  = 8'd0;
               w_next_pass_count = 4'd0;
               w_next_pass       = 1'b0;
            end
         end
         S_DRIVE: begin
            if (r_cnt == 4'd0) w_next_state = S_SAMPLE;
            else               w_next_cnt   = r_cnt - 4'd1;
         end
         S_SAMPLE: begin
            w_next_fail_mask = w_fail_upd;
            if (w_match) w_next_pass_count = r_pass_count + 4'd1;
            // The verdict includes the result of this final sample.
            if (r_code == 3'd7) begin
               w_next_state = S_FIN;
               w_next_pass  = (w_fail_upd == 8'd0);
            end else begin
               w_next_state = S_DRIVE;
               w_next_code  = r_code + 3'd1;
               w_next_cnt   = RELOAD;
            end
         end
         S_FIN: begin
            w_next_state = S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // Drive lines come straight from the code register, so START never reaches them combinationally.
   assign AA         = r_code[2];
   assign BB         = r_code[1];
   assign CC         = r_code[0];
   assign CODE       = r_code;
   assign BUSY       = (r_state == S_DRIVE) || (r_state == S_SAMPLE);
   assign DONE       = (r_state == S_FIN);
   assign PASS       = r_pass;
   assign FAIL_MASK  = r_fail_mask;
   assign PASS_COUNT = r_pass_count;
   assign DBG_STATE  = r_state;

endmodule

// File: tb/tb_challenge_b_sequencer.sv
// Bench for challenge_b_sequencer: directed sweeps against a behavioural datapath,
// with a DONE-triggered scoreboard and a per-cycle code-sequence monitor.
module tb_challenge_b_sequencer;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic       start_a = 1'b0, start_b = 1'b0;
   logic       yy_a, yy_b;
   int         mode_a = 0, mode_b = 0;

   logic       aa_a, bb_a, cc_a, busy_a, done_a, pass_a;
   logic [2:0] code_a;
   logic [7:0] fmask_a;
   logic [3:0] pcnt_a;
   logic [1:0] st_a;
   logic       aa_b, bb_b, cc_b, busy_b, done_b, pass_b;
   logic [2:0] code_b;
   logic [7:0] fmask_b;
   logic [3:0] pcnt_b;
   logic [1:0] st_b;

   // Expected response per sweep: {FAIL_MASK, PASS_COUNT, PASS}
   logic [12:0] exp_q_a[$];
   logic [12:0] exp_q_b[$];

   int n_checks = 0;
   int n_fail   = 0;
   int busy_cnt_a = 0, busy_cnt_b = 0;
   int dones_a = 0, dones_b = 0;

   always #5 CLK = ~CLK;

   challenge_b_sequencer u_dut_a (
      .CLK(CLK), .RESET(RESET), .START(start_a), .YY(yy_a),
      .AA(aa_a), .BB(bb_a), .CC(cc_a), .CODE(code_a), .BUSY(busy_a), .DONE(done_a),
      .PASS(pass_a), .FAIL_MASK(fmask_a), .PASS_COUNT(pcnt_a), .DBG_STATE(st_a)
   );

   challenge_b_sequencer #(.SETTLE_CYCLES(1)) u_dut_b (
      .CLK(CLK), .RESET(RESET), .START(start_b), .YY(yy_b),
      .AA(aa_b), .BB(bb_b), .CC(cc_b), .CODE(code_b), .BUSY(busy_b), .DONE(done_b),
      .PASS(pass_b), .FAIL_MASK(fmask_b), .PASS_COUNT(pcnt_b), .DBG_STATE(st_b)
   );

   // Datapath model: 0 = correct (YY high for codes 2 and 5), 1 = stuck at 0, 2 = stuck at 1
   function automatic logic yy_model(input int mode, input logic [2:0] code);
      case (mode)
         1:       return 1'b0;
         2:       return 1'b1;
         default: return (code == 3'd2) || (code == 3'd5);
      endcase
   endfunction

   always_comb yy_a = yy_model(mode_a, {aa_a, bb_a, cc_a});
   always_comb yy_b = yy_model(mode_b, {aa_b, bb_b, cc_b});

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor A: code sequence while busy and scoreboard pop on DONE
   always @(negedge CLK) begin
      logic [12:0] e;
      if (busy_a) begin
         if (busy_cnt_a == 0)
            check("a_cleared_at_start", {fmask_a, pcnt_a, pass_a}, 13'd0);
         check("a_code_seq", {29'd0, code_a}, busy_cnt_a / 3);
         check("a_abc_seq", {29'd0, aa_a, bb_a, cc_a}, busy_cnt_a / 3);
         busy_cnt_a++;
      end
      if (done_a) begin
         dones_a++;
         check("a_busy_length", busy_cnt_a, 24);
         if (exp_q_a.size() == 0) begin
            check("a_done_without_expect", exp_q_a.size(), 1);
         end else begin
            e = exp_q_a.pop_front();
            check("a_fail_mask", {24'd0, fmask_a}, {24'd0, e[12:5]});
            check("a_pass_count", {28'd0, pcnt_a}, {28'd0, e[4:1]});
            check("a_pass", {31'd0, pass_a}, {31'd0, e[0]});
         end
      end
      if (!busy_a) busy_cnt_a = 0;
   end

   // Monitor B: same for the SETTLE_CYCLES=1 instance
   always @(negedge CLK) begin
      logic [12:0] e;
      if (busy_b) begin
         if (busy_cnt_b == 0)
            check("b_cleared_at_start", {fmask_b, pcnt_b, pass_b}, 13'd0);
         check("b_code_seq", {29'd0, code_b}, busy_cnt_b / 2);
         busy_cnt_b++;
      end
      if (done_b) begin
         dones_b++;
         check("b_busy_length", busy_cnt_b, 16);
         if (exp_q_b.size() == 0) begin
            check("b_done_without_expect", exp_q_b.size(), 1);
         end else begin
            e = exp_q_b.pop_front();
            check("b_fail_mask", {24'd0, fmask_b}, {24'd0, e[12:5]});
            check("b_pass_count", {28'd0, pcnt_b}, {28'd0, e[4:1]});
            check("b_pass", {31'd0, pass_b}, {31'd0, e[0]});
         end
      end
      if (!busy_b) busy_cnt_b = 0;
   end

   task automatic check_reset_a(input string tag);
      check({tag, "_code"}, {29'd0, code_a}, 0);
      check({tag, "_abc"}, {29'd0, aa_a, bb_a, cc_a}, 0);
      check({tag, "_busy_done"}, {30'd0, busy_a, done_a}, 0);
      check({tag, "_pass"}, {31'd0, pass_a}, 0);
      check({tag, "_fail_mask"}, {24'd0, fmask_a}, 0);
      check({tag, "_pass_count"}, {28'd0, pcnt_a}, 0);
      check({tag, "_state"}, {30'd0, st_a}, 0);
   endtask

   task automatic wait_done_a(output int k);
      k = 1;
      while (!done_a && k < 200) begin
         @(negedge CLK);
         k++;
      end
      check("a_done_seen", {31'd0, done_a}, 1);
   endtask

   task automatic wait_code_a(input logic [2:0] c);
      int k = 0;
      while (code_a != c && k < 200) begin
         @(negedge CLK);
         k++;
      end
      check("a_code_reached", {29'd0, code_a}, {29'd0, c});
   endtask

   task automatic run_sweep_a(input int mode, input logic [12:0] exp);
      int k;
      mode_a = mode;
      exp_q_a.push_back(exp);
      @(negedge CLK) start_a = 1'b1;
      @(negedge CLK) start_a = 1'b0;
      wait_done_a(k);
      check("a_done_latency", k, 25);
      @(negedge CLK);
      check("a_idle_after_done", {30'd0, busy_a, done_a}, 0);
   endtask

   initial begin
      int k, d0;
      repeat (3) @(negedge CLK);
      check_reset_a("rst");
      @(negedge CLK) RESET = 1'b0;

      // Correct datapath, stuck-at-0, stuck-at-1
      run_sweep_a(0, {8'h00, 4'd8, 1'b1});
      repeat (5) @(negedge CLK);
      check("a_hold_in_idle", {fmask_a, pcnt_a, pass_a}, {8'h00, 4'd8, 1'b1});
      run_sweep_a(1, {8'h24, 4'd6, 1'b0});
      run_sweep_a(2, {8'hDB, 4'd2, 1'b0});
      repeat (4) @(negedge CLK);
      check("a_hold_after_stuck1", {fmask_a, pcnt_a, pass_a}, {8'hDB, 4'd2, 1'b0});

      // START pulsed during code 3 must be ignored
      mode_a = 0;
      d0 = dones_a;
      exp_q_a.push_back({8'h00, 4'd8, 1'b1});
      @(negedge CLK) start_a = 1'b1;
      @(negedge CLK) start_a = 1'b0;
      wait_code_a(3'd3);
      start_a = 1'b1;
      @(negedge CLK) start_a = 1'b0;
      wait_done_a(k);
      repeat (30) @(negedge CLK);
      check("a_single_done", dones_a - d0, 1);
      check("a_idle_after_ignored_start", {30'd0, busy_a, done_a}, 0);

      // RESET during code 4 aborts the sweep with no DONE
      d0 = dones_a;
      exp_q_a.push_back({8'h00, 4'd8, 1'b1});
      @(negedge CLK) start_a = 1'b1;
      @(negedge CLK) start_a = 1'b0;
      wait_code_a(3'd4);
      @(negedge CLK) RESET = 1'b1;
      @(negedge CLK);
      check_reset_a("abort");
      RESET = 1'b0;
      exp_q_a.delete();
      repeat (30) @(negedge CLK);
      check("a_no_done_after_abort", dones_a - d0, 0);
      run_sweep_a(0, {8'h00, 4'd8, 1'b1});

      // START held high on the SETTLE_CYCLES=1 instance: back-to-back sweeps
      exp_q_b.push_back({8'hDB, 4'd2, 1'b0});
      exp_q_b.push_back({8'h00, 4'd8, 1'b1});
      exp_q_b.push_back({8'h24, 4'd6, 1'b0});
      mode_b = 2;
      @(negedge CLK) start_b = 1'b1;
      for (int s = 0; s < 3; s++) begin
         k = 0;
         @(negedge CLK);
         while (!done_b && k < 200) begin
            @(negedge CLK);
            k++;
         end
         check("b_done_seen", {31'd0, done_b}, 1);
         mode_b = (s == 0) ? 0 : 1;
         if (s == 2) start_b = 1'b0;
         @(negedge CLK);
         check("b_idle_after_done", {30'd0, busy_b, done_b}, 0);
         if (s < 2) begin
            @(negedge CLK);
            check("b_busy_again", {31'd0, busy_b}, 1);
         end
      end
      repeat (20) @(negedge CLK);
      check("b_stays_idle", {31'd0, busy_b}, 0);
      check("b_sweep_count", dones_b, 3);

      check("a_queue_drained", exp_q_a.size(), 0);
      check("b_queue_drained", exp_q_b.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
